ram_panel: RTL
==============

Name: ram_panel

Overview:
Button/switch front panel that drives one dev_ram port through a small command FSM.
- Generalises the single-byte board test controller to parametrised address and data widths.
- Adds multi-byte shift-in entry, selectable access size, address auto-increment, debounced inputs and a lane-selectable display.
- Sits between board I/O (8 switches, 3 buttons) and dev_ram/dev_hex at the board top level.

Parameters:
ADDRW, pkg_ram::RAM_ADDRW, RAM address width (>= 8).
DATAW, pkg_ram::RAM_LONG_SIZE, RAM data width; multiple of 8, >= 16.
DEBOUNCE_CYCLES, 65536, cycles a raw button must stay stable before its debounced level changes (>= 2).
RAM_LAT, 1, cycles from op issue to valid ram_data_out (>= 1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sw  in  8  switch byte, already synchronised by the top level
btn  in  3  raw asynchronous buttons; btn[2] is the modifier
ram_op  out  pkg_ram::ram_op_t  RAM operation, one-cycle STORE/FETCH pulse, else NOP
ram_data_type  out  pkg_ram::ram_data_type_t  access size of the current op
ram_addr  out  ADDRW  address register
ram_data_in  out  DATAW  store data register
ram_data_out  in  DATAW  RAM read data
disp_byte  out  8  byte of view register at current lane, to dev_hex
disp_fits_byte  out  1  high when view[DATAW-1:8] == 0
busy  out  1  high while FSM is not IDLE

Behaviour:
- Reset: all of the following are cleared synchronously.
  - ram_addr, ram_data_in, view and lane = 0.
  - ram_op = NOP, ram_data_type = byte, busy = 0, FSM = IDLE.
  - Debouncers read "released".
  - Therefore disp_byte = 0 and disp_fits_byte = 1.
- Debounce, per button:
  - 2-FF synchroniser feeding a counter.
  - The debounced level takes the synchronised value after DEBOUNCE_CYCLES consecutive equal samples.
  - Rise and fall produce one-cycle pulses.
  - Latency from a stable raw edge to the pulse is DEBOUNCE_CYCLES+2 cycles.
- Commands on a btn[0]/btn[1] rise pulse, accepted only in IDLE; pulses while busy are dropped.
  - btn0 rise, mod low: ram_addr <= {ram_addr[ADDRW-9:0], sw}.
  - btn0 rise, mod high: ram_data_in <= {ram_data_in[DATAW-9:0], sw}.
  - btn1 rise, mod low: STORE, with type = sw[1:0].
  - btn1 rise, mod high: FETCH, with type = sw[1:0].
  - btn0 and btn1 rising in the same cycle: btn1 wins and btn0 is ignored.
- Access size:
  - sw[1:0] encodes byte, word, long, quad = 1, 2, 4, 8 bytes.
  - Codes whose size exceeds DATAW/8 are clamped to the largest legal size.
- Lane select:
  - Falling edge of the modifier with no command accepted during that press: lane <= (lane == DATAW/8-1) ? 0 : lane+1.
  - A hold-tracking flag is set by any accepted command while the modifier is high, and cleared on the modifier rise.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  - ISSUE lasts 1 cycle: ram_op = STORE/FETCH, with ram_data_type, ram_addr and ram_data_in stable.
  - WAIT lasts RAM_LAT-1 cycles; it is skipped when RAM_LAT = 1.
  - DONE, on FETCH: view <= ram_data_out.
  - DONE, on STORE: view <= ram_data_in, masked to the access size; bytes above the access size are zero.
  - DONE, both ops: ram_addr <= ram_addr + size, wrapping modulo 2^ADDRW.
  - busy is high in ISSUE, WAIT and DONE.
  - ram_addr and ram_data_in are held constant from ISSUE through WAIT.
- Outputs:
  - disp_byte = view[8*lane +: 8], combinational from registers.
  - disp_fits_byte is combinational.
- rst in any state: next cycle is IDLE, ram_op = NOP and every register is at its reset value. The op in flight is abandoned and no address increment occurs.

Decomposition:
- pkg_ram_panel holds:
  - panel_state_t enum (IDLE, ISSUE, WAIT, DONE);
  - the size-code-to-bytes function, including the clamp;
  - localparam LANES = DATAW/8 width helper.
- pkg_ram supplies ram_op_t and ram_data_type_t.
- Sub-module: btn_debounce, one instance per button, parametrised by DEBOUNCE_CYCLES. Outputs: level, rise, fall.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, RAM_LAT=1, ADDRW=16, DATAW=64, with a behavioural RAM model.
1. Address entry: sw=0x12, press btn0; sw=0x34, press btn0 -> ram_addr=0x1234, ram_op stays NOP throughout.
2. Data entry and store: mod held, enter 0xAB then 0xCD; release mod; sw=01, press btn1 -> exactly one STORE cycle with type word, addr 0x1234, data 0xABCD; then ram_addr=0x1236, view=0xABCD, disp_byte=0xCD, disp_fits_byte=0.
3. Fetch with lanes: set ram_addr=0x1234, mod+btn1 with sw=01 -> FETCH; view=0xABCD; tap mod alone -> lane 1, disp_byte=0xAB; tap 7 more times -> lane wraps to 0.
4. Bounce and busy: btn1 glitches of 3 cycles -> no op. Second btn1 press during busy -> dropped, exactly one STORE. btn0 and btn1 rising in the same cycle -> STORE only, ram_addr not shifted.
5. Wrap and clamp: ram_addr=0xFFFE, sw=11, store -> one quad-size (8-byte) STORE, ram_addr=0x0006. Repeat with DATAW=16 -> size clamped to 2, ram_addr=0x0000.
6. Reset mid-op: assert rst during the ISSUE cycle -> next cycle ram_op=NOP, busy=0, ram_addr=0, view=0, disp_fits_byte=1.

Source files
------------

// File: rtl/pkg_ram.sv
// pkg_ram: shared RAM interface types used by dev_ram and its clients.
//   RAM_ADDRW       default RAM address width
//   RAM_LONG_SIZE   default RAM data width in bits
//   ram_op_t        NOP / STORE / FETCH operation code
//   ram_data_type_t access size code: byte, word, long, quad (1, 2, 4, 8 bytes)
package pkg_ram;
   localparam int RAM_ADDRW     = 16;
   localparam int RAM_LONG_SIZE = 64;

   typedef enum logic [1:0] {
      RAM_NOP   = 2'd0,
      RAM_STORE = 2'd1,
      RAM_FETCH = 2'd2
   } ram_op_t;

   typedef enum logic [1:0] {
      RAM_BYTE = 2'd0,
      RAM_WORD = 2'd1,
      RAM_LONG = 2'd2,
      RAM_QUAD = 2'd3
   } ram_data_type_t;
endpackage

// File: rtl/ram_panel_pkg.sv
// pkg_ram_panel: front-panel FSM states and access-size helpers.
//   panel_state_t  IDLE -> ISSUE -> WAIT -> DONE command sequence
//   LANES          byte lanes of a default-width RAM word
//   clamp_type     size code limited to the largest size that fits the data width
//   type_bytes     byte count of a size code
//   code_bytes     byte count of a raw switch code after clamping
package pkg_ram_panel;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } panel_state_t;

   localparam int LANES = pkg_ram::RAM_LONG_SIZE / 8;

   // Largest power-of-two size not above the requested code and not wider than the data bus.
   function automatic pkg_ram::ram_data_type_t clamp_type(input logic [1:0] code,
                                                          input int unsigned lanes);
      logic [1:0] best;
      best = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if ((c <= int'(code)) && ((32'd1 << c) <= lanes)) begin
            best = 2'(c);
         end
      end
      return pkg_ram::ram_data_type_t'(best);
   endfunction

   function automatic int unsigned type_bytes(input pkg_ram::ram_data_type_t t);
      return 32'd1 << t;
   endfunction

   function automatic int unsigned code_bytes(input logic [1:0] code, input int unsigned lanes);
      return type_bytes(clamp_type(code, lanes));
   endfunction
endpackage

// File: rtl/ram_panel_debounce.sv
// btn_debounce: synchroniser plus stability counter for one raw button.
//   clk, rst  system clock, synchronous active-high reset
//   raw       asynchronous button input
//   level     debounced level (0 = released)
//   rise/fall one-cycle pulses when level changes
// A raw edge that stays stable produces its pulse DEBOUNCE_CYCLES+2 cycles later.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Synchronise the raw input and accept a new level after enough equal samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
            cnt   <= '0;
            level <= sync2;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: rtl/ram_panel.sv
// ram_panel: switch/button front panel driving one dev_ram port.
//   clk, rst        system clock, synchronous active-high reset
//   sw              switch byte (already synchronised)
//   btn             raw buttons; btn[0] shift-in, btn[1] execute, btn[2] modifier
//   ram_op          one-cycle STORE/FETCH pulse, otherwise NOP
//   ram_data_type   clamped access size of the current op
//   ram_addr        address register, auto-increments by the access size
//   ram_data_in     store data register
//   ram_data_out    RAM read data, valid RAM_LAT cycles after the op
//   disp_byte       selected byte lane of the view register
//   disp_fits_byte  view has nothing above its lowest byte
//   busy            command in progress
module ram_panel
   import pkg_ram::*;
   import pkg_ram_panel::*;
#(
   parameter int ADDRW           = pkg_ram::RAM_ADDRW,
   parameter int DATAW           = pkg_ram::RAM_LONG_SIZE,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int RAM_LAT         = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              sw,
   input  logic [2:0]              btn,
   output pkg_ram::ram_op_t        ram_op,
   output pkg_ram::ram_data_type_t ram_data_type,
   output logic [ADDRW-1:0]        ram_addr,
   output logic [DATAW-1:0]        ram_data_in,
   input  logic [DATAW-1:0]        ram_data_out,
   output logic [7:0]              disp_byte,
   output logic                    disp_fits_byte,
   output logic                    busy
);
   localparam int NLANES = DATAW / 8;
   localparam int LW     = (NLANES > 1) ? $clog2(NLANES) : 1;
   localparam int WCW    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   logic [2:0]       lvl;
   logic [2:0]       rise;
   logic [2:0]       fall;
   logic             mod;
   logic             unused_levels;

   panel_state_t     state;
   panel_state_t     state_next;
   ram_op_t          cur_op;
   ram_op_t          op_sel;
   logic [WCW-1:0]   wait_cnt;
   logic [DATAW-1:0] view;
   logic [DATAW-1:0] store_view;
   logic [LW-1:0]    lane;
   logic             hold;
   logic             cmd_accept;
   logic [ADDRW-1:0] addr_step;
   int unsigned      nbytes;

   for (genvar g = 0; g < 3; g++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn[g]),
         .level (lvl[g]),
         .rise  (rise[g]),
         .fall  (fall[g])
      );
   end

   assign mod           = lvl[2];
   assign unused_levels = &{1'b0, lvl[1:0], fall[1:0]};

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; btn1 wins over btn0 because only its pulse starts a command.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (rise[1]) state_next = ISSUE;
            else         state_next = IDLE;
         end
         ISSUE: begin
            if (RAM_LAT == 1) state_next = DONE;
            else              state_next = WAIT;
         end
         WAIT: begin
            if (wait_cnt == WCW'(RAM_LAT - 2)) state_next = DONE;
            else                               state_next = WAIT;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath helpers: op selection, store masking, address step and display.
   always_comb begin
      cmd_accept = (state == IDLE) && (rise[0] || rise[1]);
      busy       = (state != IDLE);
      if (mod) op_sel = RAM_FETCH;
      else     op_sel = RAM_STORE;
      nbytes     = type_bytes(ram_data_type);
      addr_step  = ADDRW'(nbytes);
      store_view = '0;
      for (int i = 0; i < NLANES; i++) begin
         if (i < int'(nbytes)) store_view[8*i +: 8] = ram_data_in[8*i +: 8];
         else                  store_view[8*i +: 8] = 8'h00;
      end
      disp_byte      = view[{lane, 3'b000} +: 8];
      disp_fits_byte = ~|view[DATAW-1:8];
   end

   // Command registers, RAM op pulse, view capture and lane stepping.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_op        <= RAM_NOP;
         ram_data_type <= RAM_BYTE;
         ram_addr      <= '0;
         ram_data_in   <= '0;
         view          <= '0;
         lane          <= '0;
         hold          <= 1'b0;
         cur_op        <= RAM_NOP;
         wait_cnt      <= '0;
      end else begin
         ram_op <= RAM_NOP;
         case (state)
            IDLE: begin
               if (rise[1]) begin
                  cur_op        <= op_sel;
                  ram_op        <= op_sel;
                  ram_data_type <= clamp_type(sw[1:0], NLANES);
               end else if (rise[0] && mod) begin
                  ram_data_in <= DATAW'({ram_data_in, sw});
               end else if (rise[0]) begin
                  ram_addr <= ADDRW'({ram_addr, sw});
               end
            end
            ISSUE: wait_cnt <= '0;
            WAIT:  wait_cnt <= wait_cnt + WCW'(1);
            DONE: begin
               if (cur_op == RAM_FETCH) view <= ram_data_out;
               else                     view <= store_view;
               ram_addr <= ram_addr + addr_step;
            end
            default: wait_cnt <= '0;
         endcase

         // A press of the modifier that carried a command does not step the lane.
         if (cmd_accept && mod) hold <= 1'b1;
         else if (rise[2])      hold <= 1'b0;

         if (fall[2] && !hold) begin
            if (lane == LW'(NLANES - 1)) lane <= '0;
            else                         lane <= lane + LW'(1);
         end
      end
   end
endmodule
